// File: rtl/alu_pkg.sv
// Shared ALU datapath defaults: operand width, adder slice width and lookahead group size.
package alu_pkg;

  localparam int unsigned WIDTH_DEF = 64;
  localparam int unsigned SLICE_DEF = 16;
  localparam int unsigned GROUP     = 4;

  typedef logic [WIDTH_DEF-1:0] word_t;

endpackage

// File: rtl/add_slice.sv
// SLICE-bit carry-lookahead adder built from 4-bit generate/propagate groups,
// with lookahead across groups driven by group-level G/P.
module add_slice
  import alu_pkg::*;
#(
  parameter int unsigned SLICE = SLICE_DEF
) (
  input  logic [SLICE-1:0] x,
  input  logic [SLICE-1:0] y,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout
);

  localparam int unsigned NGROUP = SLICE / GROUP;

  logic [SLICE-1:0]  g;
  logic [SLICE-1:0]  p;
  logic [SLICE-1:0]  c;
  logic [NGROUP:0]   cg;
  logic [NGROUP-1:0] gg;
  logic [NGROUP-1:0] pg;

  assign g = x & y;
  assign p = x ^ y;

  // Per-group lookahead carries; each group carry-in comes from the previous group's G/P.
  always_comb begin
    c     = '0;
    gg    = '0;
    pg    = '0;
    cg    = '0;
    cg[0] = cin;
    for (int unsigned k = 0; k < NGROUP; k++) begin
      c[4*k]   = cg[k];
      c[4*k+1] = g[4*k] | (p[4*k] & cg[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
               | (p[4*k+1] & p[4*k] & cg[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
               | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & cg[k]);
      gg[k]    = g[4*k+3] | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      pg[k]    = &p[4*k +: 4];
      cg[k+1]  = gg[k] | (pg[k] & cg[k]);
    end
  end

  assign sum  = p ^ c;
  assign cout = cg[NGROUP];

endmodule

// File: rtl/sub_64_bit.sv
// Registered two's-complement subtractor S = a + ~b + 1 with no-borrow carry and
// signed-overflow flags; one register stage from operand capture to result.
module sub_64_bit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned SLICE = SLICE_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] S,
  output logic             C,
  output logic             V,
  output logic             out_valid
);

  localparam int unsigned NSLICE = WIDTH / SLICE;

  logic [WIDTH-1:0] b_inv;
  logic [WIDTH-1:0] diff;
  logic [NSLICE:0]  carry;
  logic             ovf;

  assign b_inv    = ~b;
  assign carry[0] = 1'b1;

  // Ripple the carry between slices; the +1 of the negation enters at slice 0.
  for (genvar i = 0; i < NSLICE; i++) begin : g_slice
    add_slice #(.SLICE(SLICE)) u_slice (
      .x    (a[i*SLICE +: SLICE]),
      .y    (b_inv[i*SLICE +: SLICE]),
      .cin  (carry[i]),
      .sum  (diff[i*SLICE +: SLICE]),
      .cout (carry[i+1])
    );
  end

  assign ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

  // Flags and result only load on accepted operands; out_valid tracks acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      S         <= '0;
      C         <= 1'b0;
      V         <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        S <= diff;
        C <= carry[NSLICE];
        V <= ovf;
      end
    end
  end

endmodule

// File: tb/tb_sub_64_bit.sv
// Directed table-driven bench for sub_64_bit plus reset and back-to-back sequences.
module tb_sub_64_bit;
  import alu_pkg::*;

  typedef struct {
    word_t a;
    word_t b;
    word_t s;
    logic  c;
    logic  v;
  } vec_t;

  logic  clk;
  logic  rst_n;
  logic  in_valid;
  word_t a;
  word_t b;
  word_t s_out;
  logic  c_out;
  logic  v_out;
  logic  out_valid;

  int unsigned passed;
  int unsigned total;

  sub_64_bit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .S         (s_out),
    .C         (c_out),
    .V         (v_out),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input word_t got, input word_t exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%016h expected 0x%016h", name, got, exp);
  endtask

  task automatic check_out(input string name, input word_t es, input logic ec,
                           input logic ev, input logic eo);
    check({name, ".S"}, s_out, es);
    check({name, ".C"}, word_t'(c_out), word_t'(ec));
    check({name, ".V"}, word_t'(v_out), word_t'(ev));
    check({name, ".out_valid"}, word_t'(out_valid), word_t'(eo));
  endtask

  task automatic issue(input logic vld, input word_t xa, input word_t xb);
    @(negedge clk);
    in_valid = vld;
    a        = xa;
    b        = xb;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[12];

  initial begin
    passed   = 0;
    total    = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;

    vecs[0]  = '{64'd78120, 64'd37821, 64'd40299, 1'b1, 1'b0};
    vecs[1]  = '{64'd10024, 64'd12345, 64'hFFFF_FFFF_FFFF_F6EF, 1'b0, 1'b0};
    vecs[2]  = '{-64'sd34628478, -64'sd99028374, 64'd64399896, 1'b1, 1'b0};
    vecs[3]  = '{-64'sd9782314, -64'sd9038778, -64'sd743536, 1'b0, 1'b0};
    vecs[4]  = '{64'hC000_0000_0000_0000, 64'h4000_0000_0000_0000,
                 64'h8000_0000_0000_0000, 1'b1, 1'b0};
    vecs[5]  = '{64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vecs[6]  = '{-64'sd8927, 64'd267112, -64'sd276039, 1'b1, 1'b0};
    vecs[7]  = '{64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 64'd0, 1'b1, 1'b0};
    vecs[8]  = '{64'hDEAD_BEEF_0000_FFFF, 64'd0, 64'hDEAD_BEEF_0000_FFFF, 1'b1, 1'b0};
    vecs[9]  = '{64'd0, 64'd42, -64'sd42, 1'b0, 1'b0};
    vecs[10] = '{64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
    vecs[11] = '{64'h0000_0000_FFFF_0000, 64'h0000_0000_0001_0001,
                 64'h0000_0000_FFFD_FFFF, 1'b1, 1'b0};

    #3;
    check_out("reset_initial", 64'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      issue(1'b1, vecs[i].a, vecs[i].b);
      check_out($sformatf("vec%0d", i), vecs[i].s, vecs[i].c, vecs[i].v, 1'b1);
    end

    // Reset asserted between edges clears outputs without a clock.
    issue(1'b1, 64'd5, 64'd3);
    check_out("pre_reset", 64'd2, 1'b1, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("mid_reset", 64'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(1'b1, 64'd5, 64'd3);
    check_out("post_reset", 64'd2, 1'b1, 1'b0, 1'b1);

    // Back-to-back accepted operands, then an idle cycle holding the last result.
    issue(1'b1, 64'd7, 64'd7);
    check_out("b2b_0", 64'd0, 1'b1, 1'b0, 1'b1);
    issue(1'b1, 64'd0, 64'd1);
    check_out("b2b_1", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1);
    issue(1'b1, 64'd1, 64'd0);
    check_out("b2b_2", 64'd1, 1'b1, 1'b0, 1'b1);
    issue(1'b0, 64'd9, 64'd100);
    check_out("idle_hold", 64'd1, 1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
